// File: rtl/usb_cdc_stream_fifo.sv
// usb_cdc_stream_fifo: OUT/IN FWFT byte FIFOs between usb_cdc and app pins with loopback and unconfigured flush
module usb_cdc_stream_fifo_q #(
  parameter int W = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clk_i,
  input  logic                       rstn_i,
  input  logic                       clr,
  input  logic                       push,
  input  logic [W-1:0]               wdata,
  input  logic                       pop,
  output logic [W-1:0]               rdata,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     level
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0] wr_ptr, rd_ptr;
  logic [W-1:0] mem [DEPTH];
  always_ff @(posedge clk_i or negedge rstn_i)
    if (!rstn_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
    end
  always_ff @(posedge clk_i)
    if (push && !clr) mem[wr_ptr[AW-1:0]] <= wdata;
  assign rdata = mem[rd_ptr[AW-1:0]];
  assign empty = wr_ptr == rd_ptr;
  assign full  = (wr_ptr ^ rd_ptr) == {1'b1, {AW{1'b0}}};
  assign level = wr_ptr - rd_ptr;
endmodule

module usb_cdc_stream_fifo #(
  parameter int DATA_W = 8,
  parameter int OUT_DEPTH = 16,
  parameter int IN_DEPTH = 16
) (
  input  logic                         clk_i,
  input  logic                         rstn_i,
  input  logic                         configured_i,
  input  logic                         loopback_i,
  input  logic [DATA_W-1:0]            cdc_out_data_i,
  input  logic                         cdc_out_valid_i,
  output logic                         cdc_out_ready_o,
  output logic [DATA_W-1:0]            cdc_in_data_o,
  output logic                         cdc_in_valid_o,
  input  logic                         cdc_in_ready_i,
  output logic [DATA_W-1:0]            app_out_data_o,
  output logic                         app_out_valid_o,
  input  logic                         app_out_ready_i,
  input  logic [DATA_W-1:0]            app_in_data_i,
  input  logic                         app_in_valid_i,
  output logic                         app_in_ready_o,
  output logic [$clog2(OUT_DEPTH):0]   out_level_o,
  output logic [$clog2(IN_DEPTH):0]    in_level_o,
  output logic [7:0]                   drop_cnt_o
);
  logic cfg_q, loop_q, lb;
  logic out_empty, out_full, out_push, out_pop;
  logic in_empty, in_full, in_push, in_pop;
  logic [DATA_W-1:0] out_rdata, in_wdata;
  always_ff @(posedge clk_i or negedge rstn_i)
    if (!rstn_i) begin
      cfg_q <= 1'b0;
      loop_q <= 1'b0;
      drop_cnt_o <= '0;
    end else begin
      cfg_q <= configured_i;
      loop_q <= loopback_i;
      if (!cfg_q && configured_i) drop_cnt_o <= '0;
      else if (!cfg_q && app_in_valid_i && drop_cnt_o != 8'hff) drop_cnt_o <= drop_cnt_o + 8'd1;
    end
  // loopback moves each byte in a single handshake, so mode toggles never lose or repeat one
  assign lb = cfg_q & loop_q & !out_empty & !in_full;
  assign cdc_out_ready_o = cfg_q & !out_full;
  assign out_push = cdc_out_valid_i & cdc_out_ready_o;
  assign app_out_valid_o = cfg_q & !loop_q & !out_empty;
  assign app_out_data_o = out_rdata;
  assign out_pop = lb | (app_out_valid_o & app_out_ready_i);
  assign app_in_ready_o = !cfg_q | (!loop_q & !in_full);
  assign in_push = lb | (cfg_q & !loop_q & app_in_valid_i & !in_full);
  assign in_wdata = loop_q ? out_rdata : app_in_data_i;
  assign cdc_in_valid_o = cfg_q & !in_empty;
  assign in_pop = cdc_in_valid_o & cdc_in_ready_i;
  usb_cdc_stream_fifo_q #(.W(DATA_W), .DEPTH(OUT_DEPTH)) u_out (
    .clk_i(clk_i), .rstn_i(rstn_i), .clr(!cfg_q), .push(out_push), .wdata(cdc_out_data_i),
    .pop(out_pop), .rdata(out_rdata), .empty(out_empty), .full(out_full), .level(out_level_o)
  );
  usb_cdc_stream_fifo_q #(.W(DATA_W), .DEPTH(IN_DEPTH)) u_in (
    .clk_i(clk_i), .rstn_i(rstn_i), .clr(!cfg_q), .push(in_push), .wdata(in_wdata),
    .pop(in_pop), .rdata(cdc_in_data_o), .empty(in_empty), .full(in_full), .level(in_level_o)
  );
endmodule

// File: tb/tb_usb_cdc_stream_fifo.sv
// tb_usb_cdc_stream_fifo: queue-based cycle model checks every output each cycle
module tb_usb_cdc_stream_fifo;
  logic clk = 1'b0;
  logic rstn_i, configured_i, loopback_i;
  logic [7:0] cdc_out_data_i, cdc_in_data_o, app_out_data_o, app_in_data_i, drop_cnt_o;
  logic cdc_out_valid_i, cdc_out_ready_o, cdc_in_valid_o, cdc_in_ready_i;
  logic app_out_valid_o, app_out_ready_i, app_in_valid_i, app_in_ready_o;
  logic [4:0] out_level_o, in_level_o;
  int checks = 0, errors = 0, opushed = 0;
  logic [7:0] outq[$], inq[$];
  bit cfg_m = 0, loop_m = 0;
  int drop_m = 0;
  always #5 clk = ~clk;
  usb_cdc_stream_fifo dut (
    .clk_i(clk), .rstn_i(rstn_i), .configured_i(configured_i), .loopback_i(loopback_i),
    .cdc_out_data_i(cdc_out_data_i), .cdc_out_valid_i(cdc_out_valid_i), .cdc_out_ready_o(cdc_out_ready_o),
    .cdc_in_data_o(cdc_in_data_o), .cdc_in_valid_o(cdc_in_valid_o), .cdc_in_ready_i(cdc_in_ready_i),
    .app_out_data_o(app_out_data_o), .app_out_valid_o(app_out_valid_o), .app_out_ready_i(app_out_ready_i),
    .app_in_data_i(app_in_data_i), .app_in_valid_i(app_in_valid_i), .app_in_ready_o(app_in_ready_o),
    .out_level_o(out_level_o), .in_level_o(in_level_o), .drop_cnt_o(drop_cnt_o)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    int os, is;
    bit opush, ipop, lb, opop, ipush;
    logic [7:0] b;
    os = outq.size();
    is = inq.size();
    chk("out_level", out_level_o, os);
    chk("in_level", in_level_o, is);
    chk("cdc_out_ready", cdc_out_ready_o, cfg_m && os < 16);
    chk("app_out_valid", app_out_valid_o, cfg_m && !loop_m && os != 0);
    chk("cdc_in_valid", cdc_in_valid_o, cfg_m && is != 0);
    chk("app_in_ready", app_in_ready_o, !cfg_m || (!loop_m && is < 16));
    chk("drop_cnt", drop_cnt_o, drop_m);
    if (!cfg_m) begin
      outq.delete();
      inq.delete();
      if (configured_i) drop_m = 0;
      else if (app_in_valid_i && drop_m < 255) drop_m++;
    end else begin
      opush = cdc_out_valid_i && os < 16;
      ipop = cdc_in_ready_i && is > 0;
      lb = loop_m && os > 0 && is < 16;
      opop = loop_m ? lb : (app_out_ready_i && os > 0);
      ipush = loop_m ? lb : (app_in_valid_i && is < 16);
      b = '0;
      if (ipop) chk("cdc_in_data", cdc_in_data_o, inq.pop_front());
      if (opop) begin
        b = outq.pop_front();
        if (!loop_m) chk("app_out_data", app_out_data_o, b);
      end
      if (ipush) inq.push_back(loop_m ? b : app_in_data_i);
      if (opush) begin
        outq.push_back(cdc_out_data_i);
        opushed++;
      end
    end
    cfg_m = configured_i;
    loop_m = loopback_i;
    @(negedge clk);
  endtask
  task automatic idle();
    cdc_out_valid_i = 0;
    app_in_valid_i = 0;
    app_out_ready_i = 0;
    cdc_in_ready_i = 0;
  endtask
  initial begin
    rstn_i = 0;
    configured_i = 0;
    loopback_i = 0;
    cdc_out_data_i = 0;
    app_in_data_i = 0;
    idle();
    @(negedge clk);
    @(negedge clk);
    chk("rst_cdc_out_ready", cdc_out_ready_o, 0);
    chk("rst_cdc_in_valid", cdc_in_valid_o, 0);
    chk("rst_app_out_valid", app_out_valid_o, 0);
    chk("rst_app_in_ready", app_in_ready_o, 1);
    chk("rst_levels", {out_level_o, in_level_o}, 0);
    chk("rst_drop", drop_cnt_o, 0);
    rstn_i = 1;
    configured_i = 1;
    repeat (2) tick();
    // normal flow
    app_out_ready_i = 1;
    for (int i = 0; i < 16; i++) begin
      cdc_out_valid_i = 1;
      cdc_out_data_i = 8'(i);
      tick();
    end
    cdc_out_valid_i = 0;
    repeat (3) tick();
    // fill and drain IN FIFO
    idle();
    for (int i = 1; i <= 17; i++) begin
      app_in_valid_i = 1;
      app_in_data_i = 8'(i);
      tick();
    end
    app_in_valid_i = 0;
    chk("fill_level", in_level_o, 16);
    chk("fill_ready", app_in_ready_o, 0);
    cdc_in_ready_i = 1;
    repeat (20) tick();
    chk("drain_level", in_level_o, 0);
    // random stream with wrap and simultaneous push/pop
    opushed = 0;
    for (int i = 0; i < 3000 && opushed < 100; i++) begin
      cdc_out_valid_i = 1'($urandom_range(0, 1));
      cdc_out_data_i = 8'($urandom);
      app_out_ready_i = 1'($urandom_range(0, 1));
      app_in_valid_i = 1'($urandom_range(0, 1));
      app_in_data_i = 8'($urandom);
      cdc_in_ready_i = 1'($urandom_range(0, 1));
      tick();
    end
    chk("rand_count", opushed, 100);
    idle();
    app_out_ready_i = 1;
    cdc_in_ready_i = 1;
    repeat (20) tick();
    // loopback
    idle();
    cdc_in_ready_i = 1;
    loopback_i = 1;
    tick();
    cdc_out_valid_i = 1;
    cdc_out_data_i = 8'hA5;
    tick();
    cdc_out_data_i = 8'h5A;
    tick();
    cdc_out_valid_i = 0;
    repeat (6) tick();
    loopback_i = 0;
    tick();
    // unconfigured flush and drop counter
    idle();
    for (int i = 0; i < 5; i++) begin
      cdc_out_valid_i = 1;
      cdc_out_data_i = 8'(8'h30 + i);
      tick();
    end
    cdc_out_valid_i = 0;
    chk("flush_pre_level", out_level_o, 5);
    configured_i = 0;
    repeat (2) tick();
    chk("flush_levels", {out_level_o, in_level_o}, 0);
    for (int i = 0; i < 300; i++) begin
      app_in_valid_i = 1;
      app_in_data_i = 8'(i);
      tick();
    end
    app_in_valid_i = 0;
    chk("drop_sat", drop_cnt_o, 255);
    configured_i = 1;
    tick();
    chk("drop_clear", drop_cnt_o, 0);
    // async reset mid-stream
    app_out_ready_i = 0;
    cdc_in_ready_i = 0;
    for (int i = 0; i < 4; i++) begin
      cdc_out_valid_i = 1;
      app_in_valid_i = 1;
      cdc_out_data_i = 8'(8'h60 + i);
      app_in_data_i = 8'(8'h70 + i);
      tick();
    end
    idle();
    configured_i = 0;
    #2 rstn_i = 0;
    #1;
    chk("arst_app_out_valid", app_out_valid_o, 0);
    chk("arst_cdc_in_valid", cdc_in_valid_o, 0);
    chk("arst_levels", {out_level_o, in_level_o}, 0);
    chk("arst_app_in_ready", app_in_ready_o, 1);
    outq.delete();
    inq.delete();
    cfg_m = 0;
    loop_m = 0;
    drop_m = 0;
    @(negedge clk);
    rstn_i = 1;
    repeat (3) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
